// File: rtl/display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// display_arbiter_pkg : shared BCD/segment constants and arbiter state codes
// Revision: 1.0
// ============================================================================
package display_arbiter_pkg;

    localparam logic [3:0]  BCD_DASH   = 4'hA;
    localparam logic [3:0]  BCD_BLANK  = 4'hF;
    localparam logic [15:0] FRAME_IDLE = 16'hAAAA;

    // Active-low segments, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'h0:      seg = SEG_0;
            4'h1:      seg = SEG_1;
            4'h2:      seg = SEG_2;
            4'h3:      seg = SEG_3;
            4'h4:      seg = SEG_4;
            4'h5:      seg = SEG_5;
            4'h6:      seg = SEG_6;
            4'h7:      seg = SEG_7;
            4'h8:      seg = SEG_8;
            4'h9:      seg = SEG_9;
            BCD_DASH:  seg = SEG_DASH;
            BCD_BLANK: seg = SEG_BLANK;
            default:   seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_arbiter_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver : digit scan, tear-free frame latch and registered decode
// Revision: 1.0
// ============================================================================
module seg_scan_driver
    import display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] frame_in,
    output logic [3:0]  digit,
    output logic [6:0]  display
);

    logic [SCAN_DIV-1:0] cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         frame_q, frame_d;
    logic [3:0]          digit_q, digit_d;
    logic [6:0]          display_q, display_d;
    logic                wrap;
    logic                boundary;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            frame_q   <= FRAME_IDLE;
            digit_q   <= 4'b1111;
            display_q <= SEG_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            digit_q   <= digit_d;
            display_q <= display_d;
        end
    end

    // Digit 0 of a new frame is decoded from the freshly loaded frame, so
    // all four digits of one scan always come from the same frame.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        wrap      = &cnt_q;
        boundary  = wrap && (idx_q == 2'd3);
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        frame_d   = boundary ? frame_in : frame_q;
        digit_d   = wrap ? ~(4'b0001 << idx_d) : digit_q;
        display_d = wrap ? seg_decode(frame_d[{idx_d, 2'b00} +: 4]) : display_q;
    end

    assign digit   = digit_q;
    assign display = display_q;

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// display_arbiter : fixed-priority display sharing with minimum-hold guard
// Revision: 1.0
// ============================================================================
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 1024,
    parameter int SCAN_DIV    = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] frame,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [1:0]            owner,
    output logic [3:0]            DIGIT,
    output logic [6:0]            DISPLAY
);

    localparam int              HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               any_req;
    logic [1:0]         win_idx;
    logic               owner_live;
    logic [15:0]        frame_sel;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    // Lowest-index live request wins; descending loop leaves the lowest set bit
    always_comb begin
        any_req    = |req;
        win_idx    = 2'd0;
        owner_live = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = 2'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 2'(i) && req[i]) owner_live = 1'b1;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_OWN;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                if (!owner_live) begin
                    hold_d = '0;
                    if (any_req) begin
                        gnt_d   = NUM_REQ'(1) << win_idx;
                        owner_d = win_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        owner_d = 2'd0;
                    end
                end else if (hold_q == HOLD_MAX && any_req && win_idx < owner_q) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = 2'd0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        gnt       = gnt_q;
        owner     = owner_q;
        frame_sel = FRAME_IDLE;
        if (state_q == ST_OWN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == 2'(i)) frame_sel = frame[16*i +: 16];
            end
        end
    end

    seg_scan_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .frame_in (frame_sel),
        .digit    (DIGIT),
        .display  (DISPLAY)
    );

endmodule
`default_nettype wire
